// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the timer scheduler slice.
//   - FSM state encoding (IDLE/LOAD/COUNT/DONE)
//   - default counter width and requester count
//   - terminal count value derived from the counter width
package timer_pkg;

  localparam int unsigned TIMER_W    = 8;
  localparam int unsigned TIMER_NREQ = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // All-ones value of a w-bit counter (terminal count).
  function automatic logic [31:0] max_of(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(max_of(TIMER_W));

endpackage

// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if: requester-side bus of the timer scheduler.
//   req   : level request per requester
//   delay : flattened per-requester delay, requester i at [i*W +: W]
//   grant : one-hot counter owner
//   done  : one-cycle completion pulse to the owner
//   busy  : scheduler not idle
//   count : live counter value (debug)
// master = requester side, slave = scheduler side.
interface timer_scheduler_if import timer_pkg::*; #(
  parameter int unsigned NREQ = TIMER_NREQ,
  parameter int unsigned W    = TIMER_W
) ();

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] delay;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [W-1:0]      count;

  modport master (output req, delay, input grant, done, busy, count);
  modport slave  (input req, delay, output grant, done, busy, count);

endinterface

// File: rtl/timer_core.sv
// timer_core: W-bit synchronous up-counter with preset load and a registered
// terminal pulse on wrap from MAX to 0.
//   clk, reset     : clock, synchronous active-high reset
//   preset         : load preset_value (wins over inc)
//   preset_value   : value loaded on preset
//   inc            : increment enable
//   count          : counter value
//   tc             : one-cycle pulse in the cycle after a wrap edge
module timer_core import timer_pkg::*; #(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         preset,
  input  logic [W-1:0] preset_value,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] MAX = W'(max_of(W));

  // Counter and terminal pulse; preset has priority over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (preset) begin
      count <= preset_value;
      tc    <= 1'b0;
    end else if (inc) begin
      count <= count + W'(1);
      tc    <= (count == MAX);
    end else begin
      tc    <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: shares one timer_core among NREQ one-shot delay requesters.
// A round-robin arbiter grants the counter, the FSM presets it with ~d, counts
// to the terminal value and pulses done to the owner.
//   clk, reset : clock, synchronous active-high reset
//   bus        : timer_scheduler_if slave (req/delay in, grant/done/busy/count out)
module timer_scheduler import timer_pkg::*; #(
  parameter int unsigned NREQ = TIMER_NREQ,
  parameter int unsigned W    = TIMER_W
) (
  input logic               clk,
  input logic               reset,
  timer_scheduler_if.slave  bus
);

  localparam int unsigned  IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [W-1:0] MAX = W'(max_of(W));

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [W-1:0]    dly_q, dly_d;

  logic            preset_c;
  logic            inc_c;
  logic [W-1:0]    core_count;
  logic            core_tc;

  logic [W-1:0]    d_arr [NREQ];
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;

  // Unflatten the delay bus.
  for (genvar i = 0; i < NREQ; i++) begin : g_dly
    assign d_arr[i] = bus.delay[i*W +: W];
  end

  // Round-robin pick: first set req bit searching upward from last+1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(last_q) + k) % NREQ);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    last_d   = last_q;
    gidx_d   = gidx_q;
    dly_d    = dly_q;
    preset_c = 1'b0;
    inc_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = NREQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          dly_d   = d_arr[pick_idx];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!bus.req[gidx_q]) begin
          // Abort: counter left untouched, reloaded on next grant.
          grant_d = '0;
          last_d  = gidx_q;
          state_d = ST_IDLE;
        end else begin
          preset_c = 1'b1;
          state_d  = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!bus.req[gidx_q]) begin
          grant_d = '0;
          last_d  = gidx_q;
          state_d = ST_IDLE;
        end else begin
          inc_c = 1'b1;
          if (core_count == MAX) begin
            done_d  = grant_q;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        grant_d = '0;
        last_d  = gidx_q;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= IW'(NREQ - 1);
      gidx_q  <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      dly_q   <= dly_d;
    end
  end

  // Preset value MAX-d is the bitwise complement of d.
  timer_core #(.W(W)) u_core (
    .clk          (clk),
    .reset        (reset),
    .preset       (preset_c),
    .preset_value (~dly_q),
    .inc          (inc_c),
    .count        (core_count),
    .tc           (core_tc)
  );

  // The core's wrap pulse must line up with the DONE state.
  a_tc_in_done: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_DONE) |-> core_tc);

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = core_count;

endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: scoreboard bench for timer_scheduler (NREQ=4, W=8).
// Expected (owner, grant-to-done latency) entries are queued when a request is
// driven; a negedge monitor pops and compares them on every done pulse.
module tb_timer_scheduler;
  import timer_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  typedef struct {
    int idx;
    int lat;
  } exp_t;

  logic clk;
  logic reset;

  timer_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  timer_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       sb_q[$];
  int         n_err;
  int         n_chk;
  int         cyc;
  int         g_start;
  logic [3:0] prev_grant;
  exp_t       e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic wait_grant(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("grant_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic pulse_reset();
    reset   = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
  endtask

  // One job on requester idx; delay is rewritten to d_late right after grant.
  task automatic run_job(input int idx, input logic [7:0] d, input logic [7:0] d_late);
    bus.delay[idx*W +: W] = d;
    bus.req[idx] = 1'b1;
    sb_q.push_back('{idx, int'(d) + 2});
    wait_grant(8);
    check_val("grant_owner", 32'(bus.grant), 32'(1 << idx));
    bus.delay[idx*W +: W] = d_late;
    @(negedge clk);
    check_val("preset", 32'(bus.count), 32'(TIMER_MAX - d));
    wait_done(int'(d) + 8);
    bus.req[idx] = 1'b0;
    @(negedge clk);
    check_val("grant_release", 32'(bus.grant), 32'd0);
  endtask

  // Done monitor: owner and latency from the grant rising edge.
  initial begin
    cyc        = 0;
    g_start    = 0;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (bus.grant != '0 && prev_grant == '0) g_start = cyc;
      if (bus.done != '0) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("done_owner", 32'(bus.done), 32'(1 << e.idx));
          check_val("done_grant", 32'(bus.grant), 32'(1 << e.idx));
          check_val("done_latency", 32'(cyc - g_start), 32'(e.lat));
        end
      end
      prev_grant = bus.grant;
      cyc++;
    end
  end

  initial begin
    logic [3:0] exp_g;
    n_err     = 0;
    n_chk     = 0;
    reset     = 1'b1;
    bus.req   = '0;
    bus.delay = '0;
    repeat (3) @(negedge clk);
    check_val("rst_grant", 32'(bus.grant), 32'd0);
    check_val("rst_done",  32'(bus.done),  32'd0);
    check_val("rst_busy",  32'(bus.busy),  32'd0);
    check_val("rst_count", 32'(bus.count), 32'd0);
    reset = 1'b0;

    // Single request, d=5.
    bus.delay[0 +: W] = 8'd5;
    bus.req = 4'b0001;
    sb_q.push_back('{0, 7});
    wait_grant(8);
    check_val("single_busy", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_val("single_grant", 32'(bus.grant), (k < 8) ? 32'd1 : 32'd0);
      if (k <= 7) check_val("single_count", 32'(bus.count), (k <= 6) ? 32'(249 + k) : 32'd0);
      if (k == 7) bus.req = '0;
    end
    check_val("single_idle_busy", 32'(bus.busy), 32'd0);

    // Round-robin with all d=0 from a fresh reset.
    pulse_reset();
    bus.delay = '0;
    bus.req   = 4'b1111;
    for (int j = 0; j < 5; j++) sb_q.push_back('{j % 4, 2});
    wait_grant(8);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      exp_g = (c % 4 == 3) ? 4'b0000 : 4'(1 << ((c / 4) % 4));
      check_val("rr_grant", 32'(bus.grant), 32'(exp_g));
      if (c == 19) bus.req = '0;
    end
    @(negedge clk);
    check_val("rr_end", 32'(bus.grant), 32'd0);

    // Extreme delays.
    run_job(1, 8'd0, 8'd0);
    run_job(3, 8'd255, 8'd255);

    // Abort: req[2] drops in COUNT, req[3] pending.
    bus.delay[2*W +: W] = 8'd20;
    bus.delay[3*W +: W] = 8'd3;
    bus.req = 4'b1100;
    sb_q.push_back('{3, 5});
    wait_grant(8);
    check_val("abort_owner", 32'(bus.grant), 32'd4);
    repeat (4) @(negedge clk);
    bus.req[2] = 1'b0;
    @(negedge clk);
    check_val("abort_grant", 32'(bus.grant), 32'd0);
    check_val("abort_busy",  32'(bus.busy),  32'd0);
    check_val("abort_done",  32'(bus.done),  32'd0);
    check_val("abort_hold",  32'(bus.count), 32'd238);
    @(negedge clk);
    check_val("abort_next", 32'(bus.grant), 32'd8);
    wait_done(12);
    bus.req = '0;
    @(negedge clk);
    check_val("abort_release", 32'(bus.grant), 32'd0);

    // Reset in the 4th COUNT cycle; round-robin pointer must restart.
    bus.delay = {4{8'd10}};
    bus.req   = 4'b0100;
    wait_grant(8);
    check_val("rst_mid_owner", 32'(bus.grant), 32'd4);
    repeat (4) @(negedge clk);
    reset   = 1'b1;
    bus.req = 4'b1111;
    sb_q.push_back('{0, 12});
    @(negedge clk);
    check_val("rst_mid_grant", 32'(bus.grant), 32'd0);
    check_val("rst_mid_done",  32'(bus.done),  32'd0);
    check_val("rst_mid_busy",  32'(bus.busy),  32'd0);
    check_val("rst_mid_count", 32'(bus.count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_first", 32'(bus.grant), 32'd1);
    wait_done(20);
    bus.req = '0;
    @(negedge clk);
    check_val("rst_release", 32'(bus.grant), 32'd0);

    // Delay change after grant is ignored.
    run_job(1, 8'd6, 8'd40);

    repeat (5) @(negedge clk);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
